display_sched: RTL and testbench
================================

DISPLAY_SCHED -- requirements
Module: display_sched

Interface
REQ-001 Parameter NREQ, default 4, meaning number of command requesters (2..8).
REQ-002 Parameter LOCK_TIMEOUT, default 255, meaning idle cycles before a stale lock is forcibly released.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester command pending; held until matching ack.
REQ-006 req_cmd  input  4*NREQ  per-requester opcode, slice i = [4i+3:4i].
REQ-007 req_data  input  64*NREQ  per-requester payload, slice i = [64i+63:64i].
REQ-008 req_lock  input  NREQ  high with a command: keep ownership for the next command.
REQ-009 req_ack  output  NREQ  one-cycle pulse; the requester's command was consumed.
REQ-010 disp_cmd  output  4  opcode to display engine; 4'h0 = NOP.
REQ-011 disp_data  output  64  payload to display engine.
REQ-012 disp_ready  input  1  display engine idle and accepting.
REQ-013 drop  output  1  one-cycle pulse when a command is acked but not issued.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, ISSUE and WAIT; all outputs registered.
REQ-016 IDLE: arbitration SHALL occur only when disp_ready=1 and at least one eligible req_valid bit is set.
REQ-017 Round-robin SHALL search from last_grant+1 modulo NREQ; the first valid index wins.
REQ-018 While a lock owner exists, only the owner SHALL be eligible.
REQ-019 On a win with opcode 1..3: next cycle state=ISSUE, disp_cmd/disp_data = winner's cmd/data, req_ack[winner]=1, last_grant=winner.
REQ-020 ISSUE SHALL last exactly one cycle, then go to WAIT with disp_cmd=0; disp_data holds.
REQ-021 WAIT SHALL keep disp_cmd=0 and go to IDLE on the first cycle disp_ready=1.
REQ-022 The minimum spacing between two issued commands SHALL be 3 cycles: ISSUE, WAIT, IDLE.
REQ-023 On a win with opcode 0 or greater than 3: next cycle req_ack[winner]=1, drop=1, disp_cmd stays 0, and state stays IDLE; last_grant and lock update as for an issued command.
REQ-024 Lock: on a win with req_lock[winner]=1, the owner SHALL become the winner.
REQ-025 Lock: on a win with req_lock[winner]=0, the owner SHALL be cleared.
REQ-026 Lock timeout: while an owner exists, the state is IDLE and req_valid[owner]=0, an 8+ bit counter SHALL increment.
REQ-027 Lock timeout: the counter SHALL reset on any grant; at LOCK_TIMEOUT the owner SHALL be cleared.
REQ-028 Only one req_ack bit SHALL be high in any cycle; req_ack SHALL never assert while rst=1.
REQ-029 A req_valid that drops before its ack SHALL be ignored; no ack is generated.
REQ-030 disp_ready=1 seen in ISSUE SHALL be ignored.

Reset
REQ-031 On rst: state=IDLE; disp_cmd=0; disp_data=0; req_ack=0; drop=0; busy=0; last_grant=NREQ-1; lock owner cleared; timeout counter=0.
REQ-032 Reset mid-ISSUE/WAIT SHALL NOT wait for the engine; REQ-016 (disp_ready gating) prevents a premature issue.

Structure
REQ-033 Package display_pkg SHALL hold CMD_NOP=4'h0, CMD_SCROLL=4'h1, CMD_POS_CLEAR=4'h2, CMD_NUMBER=4'h3, CMD_LAST=4'h3, and the state encoding.
REQ-034 Round-robin selection SHALL be the combinational sub-module rr_arbiter (request mask, last_grant in; one-hot grant and index out).

Verification
REQ-035 req_valid=4'b0110, all cmd=1, disp_ready always 1 -> grant order 1,2,1,2; disp_cmd=1 for exactly one cycle every 3 cycles.
REQ-036 Single issue of cmd=3, data=64'h0000_0A05_0000_007B; disp_ready low 20 cycles after ISSUE -> no new ISSUE until ready returns; disp_data unchanged throughout.
REQ-037 Req 0 issues cmd=2 with lock=1, then cmd=3 with lock=0, while req 3 is valid throughout -> req 3 is granted only after req 0's cmd=3 ack.
REQ-038 Req 2 issues with lock=1, then valid low; LOCK_TIMEOUT=16 -> lock released after 16 idle cycles; req 1 granted next.
REQ-039 Req 1 issues cmd=7 -> req_ack[1] and drop pulse together; disp_cmd stays 0; state stays IDLE.
REQ-040 Assert rst for 1 cycle during WAIT with disp_ready=0 -> all outputs at reset values next cycle; no ISSUE until disp_ready=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display command scheduler: engine opcodes and the
// scheduler FSM state encoding.
package display_pkg;

   localparam logic [3:0] CMD_NOP       = 4'h0;
   localparam logic [3:0] CMD_SCROLL    = 4'h1;
   localparam logic [3:0] CMD_POS_CLEAR = 4'h2;
   localparam logic [3:0] CMD_NUMBER    = 4'h3;
   localparam logic [3:0] CMD_LAST      = 4'h3;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;

   // Opcodes outside SCROLL..LAST are consumed but never reach the engine.
   function automatic logic cmd_issuable(input logic [3:0] cmd);
      return (cmd >= CMD_SCROLL) && (cmd <= CMD_LAST);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 (mod NREQ) and
// returns the first requesting index as both one-hot and binary.
module rr_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand = IDX_W'((32'(last_grant) + off) % NREQ);
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/display_sched.sv
// Display command scheduler: round-robin arbitration of NREQ requesters onto a
// single display engine, with per-requester ownership locks and a stale-lock timeout.
module display_sched
   import display_pkg::*;
#(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned LOCK_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [4*NREQ-1:0]    req_cmd,
   input  logic [64*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]      req_lock,
   output logic [NREQ-1:0]      req_ack,
   output logic [3:0]           disp_cmd,
   output logic [63:0]          disp_data,
   input  logic                 disp_ready,
   output logic                 drop,
   output logic                 busy
);

   localparam int unsigned IDX_W = $clog2(NREQ);
   localparam int unsigned CNT_W =
      ($clog2(LOCK_TIMEOUT + 1) > 8) ? $clog2(LOCK_TIMEOUT + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic             lock_vld_q, lock_vld_d;
   logic [IDX_W-1:0] lock_own_q, lock_own_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             drop_q, drop_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [63:0]      data_q, data_d;
   logic             busy_q, busy_d;

   logic [NREQ-1:0]  owner_mask;
   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  arb_grant;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;
   logic [3:0]       win_cmd;
   logic [63:0]      win_data;
   logic             win_lock;
   logic             owner_idle;

   always_comb begin
      owner_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         owner_mask[i] = !lock_vld_q || (lock_own_q == IDX_W'(i));
      end
   end

   // A requester being acked this cycle is still showing its consumed command.
   assign eligible   = req_valid & owner_mask & ~ack_q;
   assign owner_idle = lock_vld_q && !req_valid[lock_own_q];

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req         (eligible),
      .last_grant  (last_grant_q),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   always_comb begin
      win_cmd  = '0;
      win_data = '0;
      win_lock = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) begin
            win_cmd  = req_cmd[4*i +: 4];
            win_data = req_data[64*i +: 64];
            win_lock = req_lock[i];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lock_vld_d   = lock_vld_q;
      lock_own_d   = lock_own_q;
      cnt_d        = cnt_q;
      ack_d        = '0;
      drop_d       = 1'b0;
      cmd_d        = cmd_q;
      data_d       = data_q;

      unique case (state_q)
         StIdle: begin
            if (disp_ready && arb_valid) begin
               ack_d        = arb_grant;
               last_grant_d = arb_idx;
               lock_vld_d   = win_lock;
               lock_own_d   = arb_idx;
               cnt_d        = '0;
               if (cmd_issuable(win_cmd)) begin
                  state_d = StIssue;
                  cmd_d   = win_cmd;
                  data_d  = win_data;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (owner_idle) begin
               if (cnt_q == CNT_LAST) begin
                  lock_vld_d = 1'b0;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StIssue: begin
            state_d = StWait;
            cmd_d   = CMD_NOP;
         end
         StWait: begin
            if (disp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= LAST_INIT;
         lock_vld_q   <= 1'b0;
         lock_own_q   <= '0;
         cnt_q        <= '0;
         ack_q        <= '0;
         drop_q       <= 1'b0;
         cmd_q        <= CMD_NOP;
         data_q       <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lock_vld_q   <= lock_vld_d;
         lock_own_q   <= lock_own_d;
         cnt_q        <= cnt_d;
         ack_q        <= ack_d;
         drop_q       <= drop_d;
         cmd_q        <= cmd_d;
         data_q       <= data_d;
         busy_q       <= busy_d;
      end
   end

   assign req_ack   = ack_q;
   assign drop      = drop_q;
   assign disp_cmd  = cmd_q;
   assign disp_data = data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_display_sched.sv
// Bench for display_sched: directed scenarios plus random traffic, every cycle
// checked against a cycle-level reference model of the scheduling rules.
module tb_display_sched;

   localparam int NREQ = 4;
   localparam int TO   = 16;

   typedef struct {
      logic [3:0]  cmd;
      logic [63:0] data;
      logic        lock;
   } cmd_t;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [4*NREQ-1:0]   req_cmd;
   logic [64*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     req_lock;
   logic [NREQ-1:0]     req_ack;
   logic [3:0]          disp_cmd;
   logic [63:0]         disp_data;
   logic                disp_ready;
   logic                drop;
   logic                busy;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Requester side: scripted command queues, optional random traffic.
   cmd_t q [NREQ][$];
   int   hold [NREQ];
   bit   rand_on;

   // Reference model: phase 0 idle, 1 issuing, 2 waiting for the engine.
   int              m_phase;
   int              m_last;
   int              m_owner;
   int              m_idle;
   logic [NREQ-1:0] e_ack;
   logic            e_drop;
   logic [3:0]      e_cmd;
   logic [63:0]     e_data;
   logic            e_busy;

   int order [$];
   int t_a, t_b;

   always #5 clk = ~clk;

   display_sched #(
      .NREQ         (NREQ),
      .LOCK_TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_cmd    (req_cmd),
      .req_data   (req_data),
      .req_lock   (req_lock),
      .req_ack    (req_ack),
      .disp_cmd   (disp_cmd),
      .disp_data  (disp_data),
      .disp_ready (disp_ready),
      .drop       (drop),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic present(input int i, input logic [3:0] c, input logic [63:0] d,
                          input logic l);
      req_valid[i]         = 1'b1;
      req_cmd[4*i +: 4]    = c;
      req_data[64*i +: 64] = d;
      req_lock[i]          = l;
   endtask

   task automatic push(input int i, input logic [3:0] c, input logic [63:0] d,
                       input logic l);
      cmd_t e;
      e.cmd  = c;
      e.data = d;
      e.lock = l;
      q[i].push_back(e);
   endtask

   task automatic stim_phase();
      cmd_t e;
      for (int i = 0; i < NREQ; i++) begin
         if (hold[i] > 0) begin
            hold[i]--;
         end else if (!req_valid[i] && q[i].size() > 0) begin
            e = q[i].pop_front();
            present(i, e.cmd, e.data, e.lock);
         end else if (rand_on) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               present(i, 4'($urandom_range(0, 7)), {$urandom, $urandom},
                       ($urandom_range(0, 3) == 0));
            else if (req_valid[i] && $urandom_range(0, 19) == 0)
               req_valid[i] = 1'b0;
         end
      end
   endtask

   // Applies the scheduling rules to the inputs about to be sampled.
   task automatic model_step();
      int win;
      int cand;
      logic [3:0] wc;
      e_ack  = '0;
      e_drop = 1'b0;
      if (rst) begin
         m_phase = 0;
         m_last  = NREQ - 1;
         m_owner = -1;
         m_idle  = 0;
         e_cmd   = '0;
         e_data  = '0;
      end else if (m_phase == 1) begin
         m_phase = 2;
         e_cmd   = '0;
      end else if (m_phase == 2) begin
         if (disp_ready) m_phase = 0;
      end else begin
         win = -1;
         if (disp_ready) begin
            for (int k = 1; k <= NREQ; k++) begin
               cand = (m_last + k) % NREQ;
               if (win < 0 && req_valid[cand] && (m_owner < 0 || m_owner == cand)) win = cand;
            end
         end
         if (win >= 0) begin
            wc         = req_cmd[4*win +: 4];
            e_ack[win] = 1'b1;
            m_last     = win;
            m_owner    = req_lock[win] ? win : -1;
            m_idle     = 0;
            if (wc >= 4'd1 && wc <= 4'd3) begin
               m_phase = 1;
               e_cmd   = wc;
               e_data  = req_data[64*win +: 64];
            end else begin
               e_drop = 1'b1;
            end
         end else if (m_owner >= 0 && !req_valid[m_owner]) begin
            m_idle++;
            if (m_idle == TO) begin
               m_owner = -1;
               m_idle  = 0;
            end
         end
      end
      e_busy = (m_phase != 0);
   endtask

   task automatic cycle();
      stim_phase();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("ack", req_ack, e_ack);
      chk("drop", drop, e_drop);
      chk("disp_cmd", disp_cmd, e_cmd);
      chk("disp_data", disp_data, e_data);
      chk("busy", busy, e_busy);
      // A consumed requester withdraws for one cycle before its next command.
      for (int i = 0; i < NREQ; i++) begin
         if (e_ack[i]) begin
            req_valid[i] = 1'b0;
            hold[i]      = 1;
         end
      end
   endtask

   task automatic run_until_ack(input int i, input int budget, output int at);
      at = -1;
      for (int c = 0; c < budget && at < 0; c++) begin
         cycle();
         if (req_ack[i] === 1'b1) at = cyc;
      end
      n_vec++;
      assert (at >= 0) else begin
         n_fail++;
         $error("FAIL ack_wait req %0d: observed no ack, expected ack within %0d cycles",
                i, budget);
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < NREQ; i++) begin
         q[i].delete();
         hold[i] = 0;
      end
      rand_on   = 1'b0;
      req_valid = '0;
      rst       = 1'b1;
      cycle();
      rst       = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_cmd    = '0;
      req_data   = '0;
      req_lock   = '0;
      disp_ready = 1'b0;
      do_reset();
      chk("rst_ack", req_ack, 0);
      chk("rst_cmd", disp_cmd, 0);
      chk("rst_data", disp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop, 0);

      // Two contenders, engine always ready: strict alternation, 3-cycle spacing.
      disp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push(1, 4'd1, 64'h1111_0000 + 64'(k), 1'b0);
         push(2, 4'd1, 64'h2222_0000 + 64'(k), 1'b0);
      end
      order.delete();
      for (int c = 0; c < 30 && order.size() < 4; c++) begin
         cycle();
         if (req_ack !== '0) order.push_back(onehot_idx(req_ack));
      end
      chk("rr_count", 64'(order.size()), 4);
      chk("rr_0", (order.size() > 0) ? order[0] : -1, 1);
      chk("rr_1", (order.size() > 1) ? order[1] : -1, 2);
      chk("rr_2", (order.size() > 2) ? order[2] : -1, 1);
      chk("rr_3", (order.size() > 3) ? order[3] : -1, 2);

      // Engine stalls after an issue: payload holds, nothing else issues.
      do_reset();
      disp_ready = 1'b1;
      push(0, 4'd3, 64'h0000_0A05_0000_007B, 1'b0);
      run_until_ack(0, 10, t_a);
      chk("stall_issue_cmd", disp_cmd, 3);
      disp_ready = 1'b0;
      push(1, 4'd1, 64'hDEAD_BEEF_0000_0001, 1'b0);
      for (int c = 0; c < 20; c++) begin
         cycle();
         chk("stall_cmd", disp_cmd, 0);
         chk("stall_data", disp_data, 64'h0000_0A05_0000_007B);
      end
      disp_ready = 1'b1;
      run_until_ack(1, 10, t_a);

      // Lock keeps req 0 in control across its two commands.
      do_reset();
      disp_ready = 1'b1;
      push(0, 4'd2, 64'hA0, 1'b1);
      push(0, 4'd3, 64'hA1, 1'b0);
      push(3, 4'd1, 64'hB0, 1'b0);
      order.delete();
      for (int c = 0; c < 30 && order.size() < 3; c++) begin
         cycle();
         if (req_ack !== '0) order.push_back(onehot_idx(req_ack));
      end
      chk("lock_0", (order.size() > 0) ? order[0] : -1, 0);
      chk("lock_1", (order.size() > 1) ? order[1] : -1, 0);
      chk("lock_2", (order.size() > 2) ? order[2] : -1, 3);

      // Stale lock: owner goes quiet, timeout frees the bus for req 1.
      do_reset();
      disp_ready = 1'b1;
      push(2, 4'd1, 64'hC0, 1'b1);
      run_until_ack(2, 10, t_a);
      push(1, 4'd2, 64'hC1, 1'b0);
      run_until_ack(1, 40, t_b);
      chk("timeout_gap", 64'(t_b - t_a), 2 + TO + 1);

      // Unsupported opcode: acked and dropped, engine untouched.
      do_reset();
      disp_ready = 1'b1;
      push(1, 4'd7, 64'hD0, 1'b0);
      run_until_ack(1, 8, t_a);
      chk("drop_pulse", drop, 1);
      chk("drop_cmd", disp_cmd, 0);
      chk("drop_busy", busy, 0);
      cycle();
      chk("drop_clear", drop, 0);

      // Reset while waiting on a stalled engine, then no issue until ready.
      do_reset();
      disp_ready = 1'b1;
      push(0, 4'd1, 64'hE0, 1'b0);
      run_until_ack(0, 10, t_a);
      disp_ready = 1'b0;
      cycle();
      push(2, 4'd2, 64'hE2, 1'b0);
      cycle();
      chk("wait_busy", busy, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_data", disp_data, 0);
      chk("midrst_ack", req_ack, 0);
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk("midrst_noissue", disp_cmd, 0);
      end
      disp_ready = 1'b1;
      run_until_ack(2, 10, t_a);

      // Random traffic with locks, withdrawals and a flaky engine.
      do_reset();
      rand_on = 1'b1;
      for (int c = 0; c < 800; c++) begin
         disp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      rand_on   = 1'b0;
      req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
